seq_detect_ctrl: RTL and testbench



---
 rtl/seq_detect_pkg.sv | 14 +
 rtl/seq_pattern_det.sv | 51 +++++
 rtl/seq_detect_ctrl.sv | 99 +++++++++
 tb/tb_seq_detect_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern-detect frame controller.
package seq_detect_pkg;

  localparam int PAT_W = 4;
  localparam logic [PAT_W-1:0] DEFAULT_PATTERN = 4'b1010;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    FLUSH,
    REPORT
  } state_e;

endpackage

// File: rtl/seq_pattern_det.sv
// Programmable 4-bit Moore detector: sliding history plus a fill count,
// with a registered match output.
module seq_pattern_det
  import seq_detect_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             bit_i,
  input  logic [PAT_W-1:0] pattern_i,
  input  logic             overlap_i,
  output logic             z_o
);

  localparam logic [2:0] FILL_MAX = 3'd4;

  logic [PAT_W-1:0] hist_q, hist_d;
  logic [2:0]       fill_q, fill_d;
  logic             z_q, z_d;

  // Non-overlapping mode restarts the fill so the next match needs fresh bits.
  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    z_d    = 1'b0;
    if (en_i) begin
      hist_d = (hist_q << 1) | {{(PAT_W-1){1'b0}}, bit_i};
      fill_d = (fill_q == FILL_MAX) ? FILL_MAX : fill_q + 3'd1;
      if ((fill_d == FILL_MAX) && (hist_d == pattern_i)) begin
        z_d = 1'b1;
        if (!overlap_i) fill_d = 3'd0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      hist_q <= '0;
      fill_q <= 3'd0;
      z_q    <= 1'b0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
      z_q    <= z_d;
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: accepts a parallel word, serialises it MSB-first into the
// pattern detector, counts hits and returns the count over a handshake.
module seq_detect_ctrl
  import seq_detect_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_we,
  input  logic [PAT_W-1:0]  cfg_pattern,
  input  logic              cfg_overlap,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [CNT_W-1:0]  out_count,
  input  logic              out_ready,
  output logic              busy,
  output logic              ser_bit,
  output logic              det_z
);

  localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

  state_e            state_q;
  logic [DATA_W-1:0] sr_q;
  logic [IDX_W-1:0]  idx_q;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PAT_W-1:0]  pat_q;
  logic              ovl_q;
  logic              det_clr;
  logic              det_en;

  assign cnt_d = (det_z && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      sr_q    <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      pat_q   <= DEFAULT_PATTERN;
      ovl_q   <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (cfg_we) begin
            pat_q <= cfg_pattern;
            ovl_q <= cfg_overlap;
          end
          if (in_valid) begin
            sr_q    <= in_data;
            idx_q   <= '0;
            cnt_q   <= '0;
            state_q <= SHIFT;
          end
        end
        SHIFT: begin
          sr_q  <= sr_q << 1;
          idx_q <= idx_q + IDX_W'(1);
          cnt_q <= cnt_d;
          if (idx_q == LAST_IDX) state_q <= FLUSH;
        end
        // The final bit's match only shows on det_z during this cycle.
        FLUSH: begin
          cnt_q   <= cnt_d;
          state_q <= REPORT;
        end
        REPORT: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign det_clr   = (state_q == IDLE) && in_valid;
  assign det_en    = (state_q == SHIFT);
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign out_count = cnt_q;
  assign ser_bit   = det_en && sr_q[DATA_W-1];

  seq_pattern_det u_det (
    .clk       (clk),
    .rst       (rst),
    .clr_i     (det_clr),
    .en_i      (det_en),
    .bit_i     (ser_bit),
    .pattern_i (pat_q),
    .overlap_i (ovl_q),
    .z_o       (det_z)
  );

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench: table of frames plus hand-written corner sequences,
// expected counts flow through a scoreboard queue.
module tb_seq_detect_ctrl;

  localparam int DATA_W = 16;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [3:0]        cfg_pattern;
  logic              cfg_overlap;
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              out_valid;
  logic [CNT_W-1:0]  out_count;
  logic              out_ready;
  logic              busy;
  logic              ser_bit;
  logic              det_z;

  int nCompared = 0;
  int nMismatch = 0;
  logic [CNT_W-1:0] expQ[$];

  typedef struct {
    logic              doCfg;
    logic [3:0]        pat;
    logic              ovl;
    logic [DATA_W-1:0] data;
    logic [CNT_W-1:0]  exp;
    string             name;
  } vec_t;

  vec_t vecs[8];

  seq_detect_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .cfg_we      (cfg_we),
    .cfg_pattern (cfg_pattern),
    .cfg_overlap (cfg_overlap),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .out_valid   (out_valid),
    .out_count   (out_count),
    .out_ready   (out_ready),
    .busy        (busy),
    .ser_bit     (ser_bit),
    .det_z       (det_z)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatch++;
      $display("[TB] FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  // Offers one frame at a negedge; returns at the first negedge after the accept edge.
  task automatic applyStimulus(input logic doCfg, input logic [3:0] pat, input logic ovl,
                               input logic [DATA_W-1:0] data, input logic [CNT_W-1:0] exp,
                               input string name);
    @(negedge clk);
    check({name, " in_ready"}, in_ready, 1);
    cfg_we      = doCfg;
    cfg_pattern = pat;
    cfg_overlap = ovl;
    in_valid    = 1'b1;
    in_data     = data;
    expQ.push_back(exp);
    @(posedge clk);
    #1;
    cfg_we   = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check({name, " ser_bit"}, ser_bit, data[DATA_W-1]);
  endtask

  // Waits for the result, checks latency and count, holds off for holdCycles, then accepts.
  task automatic checkOutput(input string name, input int startWaited, input int holdCycles);
    int waited;
    logic [CNT_W-1:0] exp;
    waited = startWaited;
    while (!out_valid && waited < 60) begin
      @(negedge clk);
      waited++;
    end
    check({name, " out_valid"}, out_valid, 1);
    check({name, " latency"}, waited, DATA_W + 2);
    if (expQ.size() > 0) begin
      exp = expQ.pop_front();
      check({name, " out_count"}, out_count, exp);
    end else begin
      exp = '0;
      check({name, " scoreboard underflow"}, 1, 0);
    end
    for (int i = 0; i < holdCycles; i++) begin
      check({name, " hold out_valid"}, out_valid, 1);
      check({name, " hold out_count"}, out_count, exp);
      check({name, " hold in_ready"}, in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({name, " out_valid drop"}, out_valid, 0);
    check({name, " idle in_ready"}, in_ready, 1);
    check({name, " idle busy"}, busy, 0);
  endtask

  initial begin
    vecs[0] = '{1'b0, 4'b0000, 1'b0, 16'hAAAA, 5'd7,  "aaaa default"};
    vecs[1] = '{1'b1, 4'b1010, 1'b0, 16'hAAAA, 5'd4,  "aaaa nonovl"};
    vecs[2] = '{1'b1, 4'b1111, 1'b1, 16'hFFFF, 5'd13, "ffff ovl"};
    vecs[3] = '{1'b1, 4'b1111, 1'b0, 16'hFFFF, 5'd4,  "ffff nonovl"};
    vecs[4] = '{1'b1, 4'b1111, 1'b1, 16'h0000, 5'd0,  "0000 p1111"};
    vecs[5] = '{1'b1, 4'b0110, 1'b1, 16'h6666, 5'd4,  "6666 p0110"};
    vecs[6] = '{1'b1, 4'b1010, 1'b1, 16'h0005, 5'd0,  "0005 p1010"};
    vecs[7] = '{1'b0, 4'b0000, 1'b0, 16'h0000, 5'd0,  "0000 after 0005"};

    rst = 1'b1; cfg_we = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset in_ready", in_ready, 1);
    check("reset out_valid", out_valid, 0);
    check("reset busy", busy, 0);
    check("reset det_z", det_z, 0);
    check("reset ser_bit", ser_bit, 0);
    check("reset out_count", out_count, 0);

    for (int v = 0; v < 8; v++) begin
      applyStimulus(vecs[v].doCfg, vecs[v].pat, vecs[v].ovl, vecs[v].data, vecs[v].exp, vecs[v].name);
      checkOutput(vecs[v].name, 1, 0);
    end

    $display("[TB] backpressure in REPORT");
    applyStimulus(1'b1, 4'b1010, 1'b1, 16'hAAAA, 5'd7, "backpressure");
    checkOutput("backpressure", 1, 5);

    $display("[TB] config write during SHIFT");
    applyStimulus(1'b0, 4'b0000, 1'b0, 16'hAAAA, 5'd7, "midcfg");
    repeat (4) @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b0000; cfg_overlap = 1'b0;
    repeat (3) @(negedge clk);
    cfg_we = 1'b0;
    checkOutput("midcfg", 8, 0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 16'hAAAA, 5'd7, "after midcfg");
    checkOutput("after midcfg", 1, 0);

    $display("[TB] reset during SHIFT");
    @(negedge clk);
    cfg_we = 1'b1; cfg_pattern = 4'b1111; cfg_overlap = 1'b1;
    in_valid = 1'b1; in_data = 16'hFFFF;
    @(posedge clk);
    #1 cfg_we = 1'b0; in_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst busy before", busy, 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("midrst in_ready", in_ready, 1);
    check("midrst busy", busy, 0);
    check("midrst out_valid", out_valid, 0);
    check("midrst out_count", out_count, 0);
    check("midrst det_z", det_z, 0);
    applyStimulus(1'b0, 4'b0000, 1'b0, 16'hAAAA, 5'd7, "default after rst");
    checkOutput("default after rst", 1, 0);

    check("scoreboard empty", expQ.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
